// File: rtl/z80fi_insn_packer.sv
// Collects opcode bytes, the pre-execution state and the state writes of one
// instruction, then presents them as a z80fi retirement packet for one cycle.
module z80fi_insn_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        insn_start,
    input  logic        fetch_valid,
    input  logic [7:0]  fetch_byte,
    input  logic        insn_done,
    input  logic [15:0] pc_in,
    input  logic [7:0]  f_in,
    input  logic [7:0]  r_in,
    input  logic        iff2_in,
    input  logic        reg_wr,
    input  logic [3:0]  reg_wnum,
    input  logic [15:0] reg_wdata,
    input  logic        f_wr,
    input  logic [7:0]  f_wdata,
    input  logic [15:0] pc_wdata,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [15:0] z80fi_pc_rdata,
    output logic [7:0]  z80fi_f_rdata,
    output logic [7:0]  z80fi_r_rdata,
    output logic        z80fi_iff2_rdata,
    output logic        z80fi_reg_wr,
    output logic [3:0]  z80fi_reg_wnum,
    output logic [15:0] z80fi_reg_wdata,
    output logic        z80fi_f_wr,
    output logic [7:0]  z80fi_f_wdata,
    output logic [15:0] z80fi_pc_wdata,
    output logic        z80fi_err,
    output logic        z80fi_abort,
    output logic [1:0]  dbg_state
);

    // Strobe semantics: every input strobe is a single-cycle qualifier with no
    // back-pressure; the packer never stalls the core.  z80fi_valid and
    // z80fi_abort are one-cycle pulses, all other packet outputs hold until the
    // next packet is loaded.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic        reg_wr;
        logic [3:0]  wnum;
        logic [15:0] wdata;
        logic        f_wr;
        logic [7:0]  f_wdata;
        logic        err;
    } acc_t;

    state_t      state;
    acc_t        cur;
    acc_t        fresh;
    acc_t        old_acc;
    acc_t        new_acc;
    acc_t        pkt_acc;
    logic [15:0] pre_pc;
    logic [7:0]  pre_f;
    logic [7:0]  pre_r;
    logic        pre_iff2;
    logic [15:0] pkt_pc;
    logic [7:0]  pkt_f;
    logic [7:0]  pkt_r;
    logic        pkt_iff2;
    logic        retire_old;
    logic        single;
    logic        abort_now;

    function automatic acc_t acc_apply(
        input acc_t        a,
        input logic        fv,
        input logic [7:0]  fb,
        input logic        rw,
        input logic [3:0]  rn,
        input logic [15:0] rd,
        input logic        fw,
        input logic [7:0]  fd
    );
        acc_t r;
        r = a;
        if (fv) begin
            if (r.len == 3'd4) begin
                r.err = 1'b1;
            end else begin
                case (r.len)
                    3'd0:    r.insn[7:0]   = fb;
                    3'd1:    r.insn[15:8]  = fb;
                    3'd2:    r.insn[23:16] = fb;
                    default: r.insn[31:24] = fb;
                endcase
                r.len = r.len + 3'd1;
            end
        end
        if (rw) begin
            if (r.reg_wr && (r.wnum != rn))
                r.err = 1'b1;
            r.reg_wr = 1'b1;
            r.wnum   = rn;
            r.wdata  = rd;
        end
        if (fw) begin
            r.f_wr    = 1'b1;
            r.f_wdata = fd;
        end
        return r;
    endfunction

    assign retire_old = (state == ACTIVE) && insn_done;
    assign single     = insn_start && insn_done && (state != ACTIVE);
    assign abort_now  = (state == ACTIVE) && insn_start && !insn_done;
    assign dbg_state  = state;

    // On a retire-and-start edge the fetch belongs to the new instruction while
    // the write strobes still belong to the retiring one.
    always_comb begin
        fresh     = '0;
        fresh.err = !fetch_valid;
        old_acc   = acc_apply(cur, fetch_valid && !insn_start, fetch_byte,
                              reg_wr, reg_wnum, reg_wdata, f_wr, f_wdata);
        new_acc   = acc_apply(fresh, fetch_valid, fetch_byte,
                              reg_wr && !retire_old, reg_wnum, reg_wdata,
                              f_wr && !retire_old, f_wdata);
        pkt_acc   = retire_old ? old_acc  : new_acc;
        pkt_pc    = retire_old ? pre_pc   : pc_in;
        pkt_f     = retire_old ? pre_f    : f_in;
        pkt_r     = retire_old ? pre_r    : r_in;
        pkt_iff2  = retire_old ? pre_iff2 : iff2_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cur              <= '0;
            pre_pc           <= '0;
            pre_f            <= '0;
            pre_r            <= '0;
            pre_iff2         <= 1'b0;
            z80fi_valid      <= 1'b0;
            z80fi_abort      <= 1'b0;
            z80fi_insn       <= '0;
            z80fi_insn_len   <= '0;
            z80fi_pc_rdata   <= '0;
            z80fi_f_rdata    <= '0;
            z80fi_r_rdata    <= '0;
            z80fi_iff2_rdata <= 1'b0;
            z80fi_reg_wr     <= 1'b0;
            z80fi_reg_wnum   <= '0;
            z80fi_reg_wdata  <= '0;
            z80fi_f_wr       <= 1'b0;
            z80fi_f_wdata    <= '0;
            z80fi_pc_wdata   <= '0;
            z80fi_err        <= 1'b0;
        end else begin
            z80fi_valid <= retire_old || single;
            z80fi_abort <= abort_now;

            if (insn_start) begin
                cur      <= new_acc;
                pre_pc   <= pc_in;
                pre_f    <= f_in;
                pre_r    <= r_in;
                pre_iff2 <= iff2_in;
            end else if (state == ACTIVE) begin
                cur <= old_acc;
            end

            if (retire_old || single) begin
                z80fi_insn       <= pkt_acc.insn;
                z80fi_insn_len   <= pkt_acc.len;
                z80fi_pc_rdata   <= pkt_pc;
                z80fi_f_rdata    <= pkt_f;
                z80fi_r_rdata    <= pkt_r;
                z80fi_iff2_rdata <= pkt_iff2;
                z80fi_reg_wr     <= pkt_acc.reg_wr;
                z80fi_reg_wnum   <= pkt_acc.wnum;
                z80fi_reg_wdata  <= pkt_acc.wdata;
                z80fi_f_wr       <= pkt_acc.f_wr;
                z80fi_f_wdata    <= pkt_acc.f_wdata;
                z80fi_pc_wdata   <= pc_wdata;
                z80fi_err        <= pkt_acc.err;
            end

            if (single || (retire_old && !insn_start))
                state <= EMIT;
            else if (insn_start || (state == ACTIVE))
                state <= ACTIVE;
            else
                state <= IDLE;
        end
    end

endmodule
